// File: rtl/branch_recovery_ctrl.sv
// Branch mispredict recovery: one-cycle flush/redirect after an accepted mispredict, then a
// youngest-to-oldest walk of the squashed ROB window, one index per cycle, with busy held throughout.
module branch_recovery_ctrl #(
   parameter int ROB_DEPTH = 32,
   parameter int TAG_W     = $clog2(ROB_DEPTH),
   parameter int XLEN      = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             b_valid_i,
   input  logic             b_mispredict_i,
   input  logic [TAG_W-1:0] b_tag_i,
   input  logic [XLEN-1:0]  b_target_pc_i,
   input  logic [TAG_W-1:0] rob_head_i,
   input  logic [TAG_W-1:0] rob_tail_i,
   output logic             flush_o,
   output logic [TAG_W-1:0] flush_tag_o,
   output logic             redirect_valid_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             walk_valid_o,
   output logic [TAG_W-1:0] walk_idx_o,
   output logic             busy_o,
   output logic             recover_done_o
);

   typedef enum logic [1:0] {IDLE, FLUSH, WALK} state_e;

   state_e           state_q, state_d;
   logic [TAG_W-1:0] stop_q, stop_d;
   logic [TAG_W-1:0] ptr_q, ptr_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             pulse_q, pulse_d;

   logic [TAG_W-1:0] tag_age, stop_age;
   logic             accept, last, done;

   always_comb begin
      tag_age  = b_tag_i - rob_head_i;
      stop_age = stop_q - rob_head_i;
      // Outside IDLE only a strictly older branch may retarget recovery.
      accept   = b_valid_i & b_mispredict_i & ((state_q == IDLE) | (tag_age < stop_age));
      last     = ((state_q == FLUSH) && (ptr_q == stop_q)) ||
                 ((state_q == WALK) && (ptr_q == stop_q + TAG_W'(1)));
      done     = last & ~accept;

      state_d = state_q;
      stop_d  = stop_q;
      ptr_d   = ptr_q;
      pc_d    = pc_q;
      pulse_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               ptr_d   = rob_tail_i - TAG_W'(1);
               state_d = FLUSH;
            end
         end
         FLUSH: state_d = done ? IDLE : WALK;
         WALK: begin
            ptr_d = ptr_q - TAG_W'(1);
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         stop_d  = b_tag_i;
         pc_d    = b_target_pc_i;
         pulse_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         stop_q  <= '0;
         ptr_q   <= '0;
         pc_q    <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
         ptr_q   <= ptr_d;
         pc_q    <= pc_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      flush_o          = pulse_q;
      flush_tag_o      = pulse_q ? stop_q : '0;
      redirect_valid_o = pulse_q;
      redirect_pc_o    = pulse_q ? pc_q : '0;
      walk_valid_o     = (state_q == WALK);
      walk_idx_o       = (state_q == WALK) ? ptr_q : '0;
      busy_o           = (state_q != IDLE);
      recover_done_o   = done;
   end

endmodule
